uart_txrx: RTL and testbench
============================

Name: uart_txrx

Overview:
- Full-duplex 8N1 UART: transmitter (UartTx function) and receiver (UartRx function) in one block, sharing clock and reset.
- Sits between a byte-level client and the serial pins.
- Two instances cross-connected (TXD of one to RXD of the other) form the system-level ping-pong link.

Parameters:
- CLKS_PER_BIT, 1042, CLK cycles per serial bit (120 MHz / 115200 baud); must be ≥ 4.

Ports:
- CLK  in  1  system clock (120 MHz nominal)
- RST_X  in  1  reset, asynchronous, active-low
- TX_DATA  in  8  byte to transmit; sampled on accepted TX_WE
- TX_WE  in  1  transmit request, one-cycle strobe
- TXD  out  1  serial output, idle high
- TX_READY  out  1  high when transmitter idle and can accept TX_WE
- RXD  in  1  serial input, asynchronous to CLK
- RX_DATA  out  8  last correctly received byte
- RX_EN  out  1  one-cycle pulse: new byte valid on RX_DATA

Behaviour:
- Clock CLK; reset RST_X, asynchronous, active-low.
- Reset values: TXD=1, TX_READY=1, RX_DATA=0x00, RX_EN=0; both state machines return to IDLE and all counters clear.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles.

TX:
- TX_WE is accepted only when TX_READY=1. On an accepted TX_WE, TX_DATA is latched.
- In the cycle after acceptance: TX_READY=0 and TXD=0 (start bit begins).
- TXD is registered (no glitches).
- After the stop bit has been driven for CLKS_PER_BIT cycles, TX_READY=1 again. Total busy time is 10*CLKS_PER_BIT cycles.
- TX_WE while busy is ignored: no queueing, and the latched data is unchanged.
- TX_WE on the same cycle TX_READY rises is accepted; back-to-back frames are allowed with no idle gap.
- TX_DATA changes after acceptance have no effect on the frame in flight.

RX:
- RXD passes through a 2-flop synchronizer, which adds 2 cycles of latency.
- IDLE: wait for synchronized RXD=0.
- START: count CLKS_PER_BIT/2 (integer division); re-sample at mid-bit. If high, treat as a glitch and return to IDLE with no RX_EN.
- DATA: sample every CLKS_PER_BIT cycles at bit centers. Shift bits in LSB first; 8 samples.
- STOP: sample one CLKS_PER_BIT later.
  - Stop=1: RX_DATA is loaded and RX_EN pulses high for exactly 1 cycle, in the same cycle.
  - Stop=0 (framing error): discard the byte. RX_DATA is unchanged, no RX_EN. Return to IDLE only after RXD is seen high.
- After a valid stop sample, return to IDLE immediately (at mid-stop-bit) so a following start edge is not missed.
- RX_DATA holds its value between frames.
- TX and RX are fully independent; simultaneous activity is allowed.
- Reset mid-frame:
  - TXD goes to 1 asynchronously; the frame is aborted.
  - The receiver drops the partial byte and does not pulse RX_EN.

Optional Feature:
- Macro UART_PARITY_EN.
- When defined:
  - An even-parity bit (XOR of the 8 data bits) is inserted between data and stop, giving an 11-bit frame; TX busy time is 11*CLKS_PER_BIT.
  - RX samples the parity bit. On mismatch the byte is discarded with no RX_EN and RX_DATA unchanged, handled the same as a framing error.
- When undefined: plain 8N1 as above, with no parity logic.
- Both ends of a link must be built with the same setting.

Test Plan:
- Loopback (TXD→RXD), CLKS_PER_BIT=16: after reset, TX_WE with TX_DATA=0x61.
  - TX_READY low for 160 cycles.
  - TXD sequence 0,1,0,0,0,0,1,1,0,1.
  - RX_EN single pulse with RX_DATA=0x61 about 152+2 cycles after TX_WE.
- Two cross-connected instances, ping-pong where each side replies with received+1, starting with 0x61 from side A: bytes 0x61, 0x62, 0x63, … alternate direction, each received value equals the previous plus 1.
- TX_WE asserted with 0x55 while transmitting 0xAA: only 0xAA is sent, TX_READY timing unchanged, exactly one RX_EN.
- RXD low pulse of 5 cycles (< CLKS_PER_BIT/2=8), then high: no RX_EN, receiver back in IDLE, and the next valid frame 0x3C is received correctly.
- Frame 0x7E driven with stop bit 0: no RX_EN, RX_DATA keeps its previous value; a following valid 0x81 gives RX_EN with 0x81.
- RST_X pulsed low mid-transmission of 0xFF: TXD=1 and TX_READY=1 immediately, no RX_EN at the loopback receiver, and a new TX_WE afterwards works normally.

Source files
------------

// File: rtl/uart_txrx.sv
// ============================================================================
// Module   : uart_txrx
// Purpose  : Full-duplex UART (8 data bits, 1 stop bit) with a transmitter
//            and a receiver in one block. Both halves share the clock and
//            reset but otherwise run independently.
// Revision : 1.0 - initial release
//
// Parameters
//   CLKS_PER_BIT : CLK cycles per serial bit (must be >= 4).
//
// Ports
//   CLK      in   system clock
//   RST_X    in   asynchronous, active-low reset
//   TX_DATA  in   [7:0] byte to send, latched when TX_WE is accepted
//   TX_WE    in   one-cycle transmit strobe, accepted only while TX_READY=1
//   TXD      out  registered serial output, idle high
//   TX_READY out  transmitter idle and able to accept TX_WE
//   RXD      in   serial input, asynchronous to CLK
//   RX_DATA  out  [7:0] last correctly received byte (held between frames)
//   RX_EN    out  one-cycle pulse when RX_DATA has been updated
//
// Build option
//   UART_PARITY_EN : when defined, an even-parity bit is inserted between the
//                    last data bit and the stop bit (11-bit frame). Received
//                    bytes with a parity mismatch are discarded.
// ============================================================================
`default_nettype none

module uart_txrx #(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       CLK,
  input  logic       RST_X,
  input  logic [7:0] TX_DATA,
  input  logic       TX_WE,
  output logic       TXD,
  output logic       TX_READY,
  input  logic       RXD,
  output logic [7:0] RX_DATA,
  output logic       RX_EN
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_PARITY_EN
  localparam int TX_BITS = 11;
`else
  localparam int TX_BITS = 10;
`endif
  // The start bit is driven straight into TXD, so the shifter holds the rest.
  localparam int SHIFT_W = TX_BITS - 1;
  localparam logic [3:0] TX_BIT_LAST = 4'(TX_BITS - 1);

  localparam logic [0:0] TXS_IDLE = 1'b0;
  localparam logic [0:0] TXS_SEND = 1'b1;

  localparam logic [2:0] RXS_IDLE   = 3'd0;
  localparam logic [2:0] RXS_START  = 3'd1;
  localparam logic [2:0] RXS_DATA   = 3'd2;
`ifdef UART_PARITY_EN
  localparam logic [2:0] RXS_PARITY = 3'd3;
`endif
  localparam logic [2:0] RXS_STOP   = 3'd4;
  localparam logic [2:0] RXS_WAIT   = 3'd5;

  // ==========================================================================
  // Transmitter
  // ==========================================================================
  logic [0:0]         tx_state_q, tx_state_d;
  logic [CNT_W-1:0]   tx_cnt_q,   tx_cnt_d;
  logic [3:0]         tx_bit_q,   tx_bit_d;
  logic [SHIFT_W-1:0] tx_shift_q, tx_shift_d;
  logic               txd_q,      txd_d;
  logic [SHIFT_W-1:0] tx_load;

  // Remaining bits of the frame after the start bit, LSB sent first.
`ifdef UART_PARITY_EN
  assign tx_load = {1'b1, ^TX_DATA, TX_DATA};
`else
  assign tx_load = {1'b1, TX_DATA};
`endif

  // State register
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      tx_state_q <= TXS_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      txd_q      <= txd_d;
    end
  end

  // Next-state logic
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TXS_IDLE: begin
        if (TX_WE) begin
          tx_state_d = TXS_SEND;
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_shift_d = tx_load;
          txd_d      = 1'b0;
        end
      end
      TXS_SEND: begin
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_bit_q == TX_BIT_LAST) begin
            // Stop bit has run its full length: release the line.
            tx_state_d = TXS_IDLE;
            txd_d      = 1'b1;
          end else begin
            tx_bit_d   = tx_bit_q + 4'd1;
            txd_d      = tx_shift_q[0];
            tx_shift_d = {1'b1, tx_shift_q[SHIFT_W-1:1]};
          end
        end else begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        tx_state_d = TXS_IDLE;
        txd_d      = 1'b1;
      end
    endcase
  end

  // Outputs
  always_comb begin
    TX_READY = (tx_state_q == TXS_IDLE);
    TXD      = txd_q;
  end

  // ==========================================================================
  // Receiver
  // ==========================================================================
  logic             rx_meta_q;
  logic             rx_sync_q;
  logic [2:0]       rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q,   rx_cnt_d;
  logic [2:0]       rx_bit_q,   rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic [7:0]       rx_data_q,  rx_data_d;
  logic             rx_en_q,    rx_en_d;
  logic             rx_err;
`ifdef UART_PARITY_EN
  logic             rx_perr_q,  rx_perr_d;
  assign rx_err = rx_perr_q;
`else
  assign rx_err = 1'b0;
`endif

  // Two-flop synchronizer; resets to the idle line level so that reset
  // release never looks like a start edge.
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= RXD;
      rx_sync_q <= rx_meta_q;
    end
  end

  // State register
  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      rx_state_q <= RXS_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_en_q    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_perr_q  <= 1'b0;
`endif
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_en_q    <= rx_en_d;
`ifdef UART_PARITY_EN
      rx_perr_q  <= rx_perr_d;
`endif
    end
  end

  // Next-state logic. After the half-bit start delay every later sample
  // lands one full bit period apart, i.e. at bit centres.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_en_d    = 1'b0;
`ifdef UART_PARITY_EN
    rx_perr_d  = rx_perr_q;
`endif
    case (rx_state_q)
      RXS_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RXS_START;
          rx_cnt_d   = '0;
        end
      end
      RXS_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d = '0;
          if (!rx_sync_q) begin
            rx_state_d = RXS_DATA;
            rx_bit_d   = '0;
          end else begin
            // Line went back high before mid-start: a glitch, not a frame.
            rx_state_d = RXS_IDLE;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RXS_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state_d = RXS_PARITY;
`else
            rx_state_d = RXS_STOP;
`endif
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_PARITY_EN
      RXS_PARITY: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_perr_d  = (^rx_shift_q) != rx_sync_q;
          rx_state_d = RXS_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
`endif
      RXS_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d = '0;
          if (rx_sync_q) begin
            // Leave at mid-stop so the next start edge is caught on time.
            rx_state_d = RXS_IDLE;
            if (!rx_err) begin
              rx_data_d = rx_shift_q;
              rx_en_d   = 1'b1;
            end
          end else begin
            // Framing error: drop the byte and wait for the line to idle.
            rx_state_d = RXS_WAIT;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RXS_WAIT: begin
        if (rx_sync_q) begin
          rx_state_d = RXS_IDLE;
        end
      end
      default: begin
        rx_state_d = RXS_IDLE;
      end
    endcase
  end

  // Outputs
  always_comb begin
    RX_DATA = rx_data_q;
    RX_EN   = rx_en_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_txrx.sv
`timescale 1ns/1ps
`default_nettype none

module tb_uart_txrx;

  localparam int N = 16;
`ifdef UART_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  // Nominal TX_WE-to-RX_EN distance in loopback: mid-stop plus sync/decode.
  localparam int LAT_LO = (FB - 1) * N + N / 2 + 2;
  localparam int LAT_HI = LAT_LO + 4;

  logic       clk = 1'b0;
  logic       rst_x;
  logic [7:0] a_tx_data, b_tx_data;
  logic       a_tx_we, b_tx_we;
  logic       a_txd, b_txd, a_tx_ready, b_tx_ready;
  logic       a_rxd, b_rxd;
  logic [7:0] a_rx_data, b_rx_data;
  logic       a_rx_en, b_rx_en;
  logic [1:0] mode;     // 0: A loopback, 1: A<->B link, 2: bench drives A.RXD
  logic       tb_rxd;

  always #5 clk = ~clk;

  assign a_rxd = (mode == 2'd0) ? a_txd : (mode == 2'd1) ? b_txd : tb_rxd;
  assign b_rxd = (mode == 2'd1) ? a_txd : 1'b1;

  uart_txrx #(.CLKS_PER_BIT(N)) u_a (
    .CLK(clk), .RST_X(rst_x), .TX_DATA(a_tx_data), .TX_WE(a_tx_we),
    .TXD(a_txd), .TX_READY(a_tx_ready), .RXD(a_rxd),
    .RX_DATA(a_rx_data), .RX_EN(a_rx_en)
  );

  uart_txrx #(.CLKS_PER_BIT(N)) u_b (
    .CLK(clk), .RST_X(rst_x), .TX_DATA(b_tx_data), .TX_WE(b_tx_we),
    .TXD(b_txd), .TX_READY(b_tx_ready), .RXD(b_rxd),
    .RX_DATA(b_rx_data), .RX_EN(b_rx_en)
  );

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         rx_cnt_a = 0;
  int         rx_cnt_b = 0;
  int         last_rx_cyc_a = 0;
  int         acc_cyc = 0;
  logic [7:0] qa[$];
  logic [7:0] qb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitors: every RX_EN must match the oldest expected byte.
  always @(negedge clk) begin
    if (a_rx_en === 1'b1) begin
      rx_cnt_a++;
      last_rx_cyc_a = cyc;
      check("a_rx_expected", 32'(qa.size() > 0), 32'd1);
      if (qa.size() > 0) check("a_rx_data", {24'd0, a_rx_data}, {24'd0, qa.pop_front()});
    end
  end

  always @(negedge clk) begin
    if (b_rx_en === 1'b1) begin
      rx_cnt_b++;
      check("b_rx_expected", 32'(qb.size() > 0), 32'd1);
      if (qb.size() > 0) check("b_rx_data", {24'd0, b_rx_data}, {24'd0, qb.pop_front()});
    end
  end

  function automatic logic [FB-1:0] frame_of(input logic [7:0] d);
`ifdef UART_PARITY_EN
    frame_of = {1'b1, ^d, d, 1'b0};
`else
    frame_of = {1'b1, d, 1'b0};
`endif
  endfunction

  task automatic wait_drain(input string tag, input bit sel_b);
    for (int i = 0; i < 600; i++) begin
      if ((sel_b ? qb.size() : qa.size()) == 0) break;
      @(negedge clk);
    end
    check(tag, sel_b ? qb.size() : qa.size(), 32'd0);
  endtask

  // Send one byte from A and watch TXD / TX_READY over the whole frame.
  task automatic send_watch(input string pfx, input logic [7:0] d, input bit busy_we);
    logic [FB-1:0] exp_frame;
    int            low_cnt;
    int            txd_err;
    exp_frame = frame_of(d);
    low_cnt   = 0;
    txd_err   = 0;
    @(negedge clk);
    check({pfx, "_ready_before"}, 32'(a_tx_ready), 32'd1);
    a_tx_data = d;
    a_tx_we   = 1'b1;
    qa.push_back(d);
    acc_cyc   = cyc;
    @(negedge clk);
    a_tx_we   = 1'b0;
    for (int i = 0; i < FB * N; i++) begin
      if (a_tx_ready !== 1'b1) low_cnt++;
      if (a_txd !== exp_frame[i / N]) txd_err++;
      if (busy_we && i == 40) begin
        a_tx_data = ~d;
        a_tx_we   = 1'b1;
      end
      if (busy_we && i == 41) begin
        a_tx_we   = 1'b0;
        a_tx_data = 8'h00;
      end
      @(negedge clk);
    end
    check({pfx, "_ready_low_cycles"}, low_cnt, FB * N);
    check({pfx, "_txd_bit_errors"}, txd_err, 0);
    check({pfx, "_ready_after"}, 32'(a_tx_ready), 32'd1);
  endtask

  task automatic drive_frame(input logic [7:0] d, input logic stop_bit);
    logic [FB-1:0] f;
    f = frame_of(d);
    f[FB-1] = stop_bit;
    for (int b = 0; b < FB; b++) begin
      tb_rxd = f[b];
      repeat (N) @(negedge clk);
    end
    tb_rxd = 1'b1;
  endtask

  initial begin
    int         cnt0;
    int         lat;
    logic [7:0] v;

    rst_x     = 1'b0;
    a_tx_data = 8'h00;
    b_tx_data = 8'h00;
    a_tx_we   = 1'b0;
    b_tx_we   = 1'b0;
    mode      = 2'd0;
    tb_rxd    = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(a_txd), 32'd1);
    check("rst_tx_ready", 32'(a_tx_ready), 32'd1);
    check("rst_rx_data", {24'd0, a_rx_data}, 32'd0);
    check("rst_rx_en", 32'(a_rx_en), 32'd0);
    rst_x = 1'b1;
    repeat (2) @(negedge clk);

    // Loopback 0x61
    cnt0 = rx_cnt_a;
    send_watch("t1", 8'h61, 1'b0);
    wait_drain("t1_drain", 1'b0);
    lat = last_rx_cyc_a - acc_cyc;
    check("t1_latency_in_window", 32'((lat >= LAT_LO) && (lat <= LAT_HI)), 32'd1);
    check("t1_rx_count", rx_cnt_a - cnt0, 1);
    check("t1_rx_data", {24'd0, a_rx_data}, 32'h61);
    repeat (20) @(negedge clk);

    // Ping-pong across two linked instances, each reply = received + 1
    mode = 2'd1;
    repeat (5) @(negedge clk);
    v = 8'h61;
    for (int k = 0; k < 6; k++) begin
      if ((k % 2) == 0) begin
        qb.push_back(8'h61 + 8'(k));
        a_tx_data = v;
        a_tx_we   = 1'b1;
        @(negedge clk);
        a_tx_we   = 1'b0;
        wait_drain("pp_b_drain", 1'b1);
        v = b_rx_data + 8'd1;
      end else begin
        qa.push_back(8'h61 + 8'(k));
        b_tx_data = v;
        b_tx_we   = 1'b1;
        @(negedge clk);
        b_tx_we   = 1'b0;
        wait_drain("pp_a_drain", 1'b0);
        v = a_rx_data + 8'd1;
      end
      @(negedge clk);
    end
    check("pp_final_next", {24'd0, v}, 32'h67);
    repeat (3 * N) @(negedge clk);

    // TX_WE while busy is ignored
    mode = 2'd0;
    repeat (5) @(negedge clk);
    cnt0 = rx_cnt_a;
    send_watch("t3", 8'hAA, 1'b1);
    wait_drain("t3_drain", 1'b0);
    repeat (3 * N) @(negedge clk);
    check("t3_rx_count", rx_cnt_a - cnt0, 1);
    check("t3_rx_data", {24'd0, a_rx_data}, 32'hAA);

    // Short low glitch on RXD, then a valid frame
    mode = 2'd2;
    repeat (5) @(negedge clk);
    cnt0 = rx_cnt_a;
    tb_rxd = 1'b0;
    repeat (5) @(negedge clk);
    tb_rxd = 1'b1;
    repeat (3 * N) @(negedge clk);
    check("t4_glitch_no_rx", rx_cnt_a - cnt0, 0);
    qa.push_back(8'h3C);
    drive_frame(8'h3C, 1'b1);
    wait_drain("t4_drain", 1'b0);
    check("t4_rx_data", {24'd0, a_rx_data}, 32'h3C);
    repeat (10) @(negedge clk);

    // Framing error, then a valid frame
    cnt0 = rx_cnt_a;
    drive_frame(8'h7E, 1'b0);
    repeat (2 * N) @(negedge clk);
    check("t5_ferr_no_rx", rx_cnt_a - cnt0, 0);
    check("t5_ferr_data_held", {24'd0, a_rx_data}, 32'h3C);
    qa.push_back(8'h81);
    drive_frame(8'h81, 1'b1);
    wait_drain("t5_drain", 1'b0);
    check("t5_rx_data", {24'd0, a_rx_data}, 32'h81);
    repeat (10) @(negedge clk);

    // Reset in the middle of a transmission
    mode = 2'd0;
    repeat (5) @(negedge clk);
    cnt0 = rx_cnt_a;
    a_tx_data = 8'hFF;
    a_tx_we   = 1'b1;
    @(negedge clk);
    a_tx_we   = 1'b0;
    repeat (80) @(negedge clk);
    check("t6_busy_before_rst", 32'(a_tx_ready), 32'd0);
    rst_x = 1'b0;
    #1;
    check("t6_rst_txd", 32'(a_txd), 32'd1);
    check("t6_rst_tx_ready", 32'(a_tx_ready), 32'd1);
    check("t6_rst_rx_data", {24'd0, a_rx_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst_x = 1'b1;
    repeat (FB * N + 40) @(negedge clk);
    check("t6_no_rx_after_abort", rx_cnt_a - cnt0, 0);
    send_watch("t6b", 8'h5A, 1'b0);
    wait_drain("t6b_drain", 1'b0);
    check("t6b_rx_data", {24'd0, a_rx_data}, 32'h5A);
    check("t6b_rx_count", rx_cnt_a - cnt0, 1);
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
